// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel coordinates, visible/strobe flags and a
// registered colour/sync output stage that keeps the pins pixel-aligned.
module vga_timing #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic       o_visible_area,
  output logic       o_frame_start,
  output logic       o_line_start,
  input  logic       i_r,
  input  logic       i_g,
  input  logic       i_b,
  output logic       o_vga_r,
  output logic       o_vga_g,
  output logic       o_vga_b,
  output logic       o_vga_hsync,
  output logic       o_vga_vsync
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds so an end value of 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [9:0] h_reg, h_next;
  logic [9:0] v_reg, v_next;
  logic       visible_reg, visible_next;
  logic       frame_start_reg, frame_start_next;
  logic       line_start_reg, line_start_next;
  logic       hsync_on, vsync_on;
  logic       hsync_reg, vsync_reg;
  logic [2:0] colour_in, colour_next, colour_reg;

  // Flags are computed from the next counter value so they line up with it.
  always_comb begin
    h_next = h_reg + 10'd1;
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_reg == V_LAST) ? '0 : v_reg + 10'd1;
    end
    visible_next     = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
    frame_start_next = (h_next == '0) && (v_next == '0);
    line_start_next  = (h_next == '0);
  end

  assign hsync_on = ({1'b0, h_reg} >= HS_START) && ({1'b0, h_reg} < HS_END);
  assign vsync_on = ({1'b0, v_reg} >= VS_START) && ({1'b0, v_reg} < VS_END);

  assign colour_in = {i_r, i_g, i_b};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_colour
      assign colour_next[gi] = colour_in[gi] & visible_reg;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_reg           <= H_LAST;
      v_reg           <= V_LAST;
      visible_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      line_start_reg  <= 1'b0;
      colour_reg      <= 3'b000;
      hsync_reg       <= SYNC_OFF;
      vsync_reg       <= SYNC_OFF;
    end else begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      visible_reg     <= visible_next;
      frame_start_reg <= frame_start_next;
      line_start_reg  <= line_start_next;
      // Pins describe the position the counters showed before this edge.
      colour_reg      <= colour_next;
      hsync_reg       <= hsync_on ? SYNC_ON : SYNC_OFF;
      vsync_reg       <= vsync_on ? SYNC_ON : SYNC_OFF;
    end
  end

  assign o_pixel_x      = h_reg;
  assign o_pixel_y      = v_reg;
  assign o_visible_area = visible_reg;
  assign o_frame_start  = frame_start_reg;
  assign o_line_start   = line_start_reg;
  assign o_vga_r        = colour_reg[2];
  assign o_vga_g        = colour_reg[1];
  assign o_vga_b        = colour_reg[0];
  assign o_vga_hsync    = hsync_reg;
  assign o_vga_vsync    = vsync_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a tiny 7x5 instance,
// both checked against a frame-position model driven by random colours.
module tb_vga_timing;

  localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVV = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int AHT = AHV + AHF + AHS + AHB;
  localparam int AVT = AVV + AVF + AVS + AVB;
  localparam int BHV = 4, BHF = 1, BHS = 1, BHB = 1;
  localparam int BVV = 2, BVF = 1, BVS = 1, BVB = 1;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic r_a = 0, g_a = 0, b_a = 0, r_b = 0, g_b = 0, b_b = 0;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_vis, a_fs, a_ls, a_r, a_g, a_b, a_hs, a_vs;
  logic b_vis, b_fs, b_ls, b_r, b_g, b_b_o, b_hs, b_vs;

  int vectors = 0;
  int miscompares = 0;

  vga_timing dut_a (
    .i_clk(clk), .i_rst(rst_a),
    .o_pixel_x(a_x), .o_pixel_y(a_y), .o_visible_area(a_vis),
    .o_frame_start(a_fs), .o_line_start(a_ls),
    .i_r(r_a), .i_g(g_a), .i_b(b_a),
    .o_vga_r(a_r), .o_vga_g(a_g), .o_vga_b(a_b),
    .o_vga_hsync(a_hs), .o_vga_vsync(a_vs)
  );

  vga_timing #(
    .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b),
    .o_pixel_x(b_x), .o_pixel_y(b_y), .o_visible_area(b_vis),
    .o_frame_start(b_fs), .o_line_start(b_ls),
    .i_r(r_b), .i_g(g_b), .i_b(b_b),
    .o_vga_r(b_r), .o_vga_g(b_g), .o_vga_b(b_b_o),
    .o_vga_hsync(b_hs), .o_vga_vsync(b_vs)
  );

  // Reference: a position index k within the frame; reset parks k on the last pixel.
  function automatic logic [22:0] pos_fields(int k, int ht, int hv, int vv);
    int x, y;
    x = k % ht;
    y = k / ht;
    return {10'(x), 10'(y), (x < hv) && (y < vv), (k == 0), (x == 0)};
  endfunction

  function automatic logic [4:0] pin_fields(int k, logic [2:0] rgb, int ht, int hv, int hf,
                                           int hs, int vv, int vf, int vs);
    int x, y;
    logic vis, hon, von;
    x   = k % ht;
    y   = k / ht;
    vis = (x < hv) && (y < vv);
    hon = (x >= hv + hf) && (x < hv + hf + hs);
    von = (y >= vv + vf) && (y < vv + vf + vs);
    return {vis ? rgb : 3'b000, !hon, !von};
  endfunction

  int ka = 0, kb = 0;
  logic [4:0] pins_a = 5'b00011, pins_b = 5'b00011;

  always @(posedge clk) begin
    if (rst_a) begin
      ka     <= AHT * AVT - 1;
      pins_a <= 5'b00011;
    end else begin
      pins_a <= pin_fields(ka, {r_a, g_a, b_a}, AHT, AHV, AHF, AHS, AVV, AVF, AVS);
      ka     <= (ka + 1) % (AHT * AVT);
    end
  end

  always @(posedge clk) begin
    if (rst_b) begin
      kb     <= BHT * BVT - 1;
      pins_b <= 5'b00011;
    end else begin
      pins_b <= pin_fields(kb, {r_b, g_b, b_b}, BHT, BHV, BHF, BHS, BVV, BVF, BVS);
      kb     <= (kb + 1) % (BHT * BVT);
    end
  end

  logic [27:0] obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {a_x, a_y, a_vis, a_fs, a_ls, a_r, a_g, a_b, a_hs, a_vs};
  assign obs_b = {b_x, b_y, b_vis, b_fs, b_ls, b_r, b_g, b_b_o, b_hs, b_vs};
  assign exp_a = {pos_fields(ka, AHT, AHV, AVV), pins_a};
  assign exp_b = {pos_fields(kb, BHT, BHV, BVV), pins_b};

  task automatic test_reset;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (obs_a !== {10'd799, 10'd524, 8'b00000011}) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected %h", obs_a, {10'd799, 10'd524, 8'b00000011});
    end
    vectors++;
    if (obs_b !== {10'd6, 10'd4, 8'b00000011}) begin
      miscompares++;
      $display("FAIL reset_b: got %h expected %h", obs_b, {10'd6, 10'd4, 8'b00000011});
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_x, a_y, a_fs, a_ls, a_hs, a_vs} !== {20'd0, 4'b1111}) begin
      miscompares++;
      $display("FAIL release_a: got x=%0d y=%0d fs=%b ls=%b expected 0 0 1 1", a_x, a_y, a_fs, a_ls);
    end
    vectors++;
    if ({b_x, b_y, b_fs, b_ls} !== {20'd0, 2'b11}) begin
      miscompares++;
      $display("FAIL release_b: got x=%0d y=%0d fs=%b ls=%b expected 0 0 1 1", b_x, b_y, b_fs, b_ls);
    end
    @(negedge clk);
    vectors++;
    if ({a_fs, a_ls, b_fs, b_ls} !== 4'b0000) begin
      miscompares++;
      $display("FAIL strobe_one_cycle: got %b expected 0000", {a_fs, a_ls, b_fs, b_ls});
    end
    vectors++;
    if (obs_a !== exp_a) begin
      miscompares++;
      $display("FAIL after_release_a: got %h expected %h", obs_a, exp_a);
    end
  endtask

  task automatic test_horizontal;
    int last_ls = -1;
    int low_run = 0;
    bit seen_fall = 0;
    logic [9:0] prev_x;
    logic prev_hs;
    for (int c = 0; c < 3 * AHT; c++) begin
      {r_a, g_a, b_a} = 3'($urandom);
      prev_x  = a_x;
      prev_hs = a_hs;
      @(negedge clk);
      vectors++;
      if (obs_a !== exp_a) begin
        miscompares++;
        $display("FAIL h_model: got %h expected %h", obs_a, exp_a);
      end
      if (a_ls) begin
        if (last_ls >= 0) begin
          vectors++;
          if (c - last_ls !== AHT) begin
            miscompares++;
            $display("FAIL line_period: got %0d expected %0d", c - last_ls, AHT);
          end
        end
        last_ls = c;
      end
      if (!a_hs) low_run++;
      if (prev_hs && !a_hs) begin
        seen_fall = 1;
        vectors++;
        if (prev_x !== 10'd656) begin
          miscompares++;
          $display("FAIL hsync_start: got x=%0d expected 656", prev_x);
        end
      end
      if (!prev_hs && a_hs) begin
        if (seen_fall) begin
          vectors++;
          if (low_run !== AHS) begin
            miscompares++;
            $display("FAIL hsync_width: got %0d expected %0d", low_run, AHS);
          end
        end
        low_run = 0;
      end
    end
  endtask

  task automatic test_colour;
    int r_cnt = 0, g_cnt = 0, g_run = 0;
    logic [9:0] prev_x, prev_y;
    logic prev_g;
    for (int c = 0; c < 4 * AHT; c++) begin
      r_a = (a_x == 10'd100);
      g_a = 1'b1;
      b_a = 1'($urandom);
      prev_x = a_x;
      prev_g = a_g;
      @(negedge clk);
      vectors++;
      if (obs_a !== exp_a) begin
        miscompares++;
        $display("FAIL colour_model_a: got %h expected %h", obs_a, exp_a);
      end
      if (a_r) begin
        r_cnt++;
        vectors++;
        if (prev_x !== 10'd100) begin
          miscompares++;
          $display("FAIL r_pulse_pos: got x=%0d expected 100", prev_x);
        end
      end
      if (a_g) begin
        g_cnt++;
        g_run++;
      end
      if (prev_g && !a_g) begin
        if (g_run != g_cnt) begin
          vectors++;
          if (g_run !== AHV) begin
            miscompares++;
            $display("FAIL g_run: got %0d expected %0d", g_run, AHV);
          end
        end
        g_run = 0;
      end
    end
    vectors++;
    if (r_cnt !== 4) begin
      miscompares++;
      $display("FAIL r_pulse_count: got %0d expected 4", r_cnt);
    end
    vectors++;
    if (g_cnt !== 4 * AHV) begin
      miscompares++;
      $display("FAIL g_count: got %0d expected %0d", g_cnt, 4 * AHV);
    end
    r_cnt = 0;
    g_cnt = 0;
    for (int c = 0; c < 2 * BHT * BVT; c++) begin
      r_b = (b_x == 10'd1);
      g_b = 1'b1;
      b_b = 1'($urandom);
      prev_x = b_x;
      prev_y = b_y;
      @(negedge clk);
      vectors++;
      if (obs_b !== exp_b) begin
        miscompares++;
        $display("FAIL colour_model_b: got %h expected %h", obs_b, exp_b);
      end
      if (b_r) r_cnt++;
      if (b_g) g_cnt++;
      if (b_r || b_g) begin
        vectors++;
        if (prev_y >= 10'(BVV) || prev_x >= 10'(BHV)) begin
          miscompares++;
          $display("FAIL blanking_b: got colour at x=%0d y=%0d expected none", prev_x, prev_y);
        end
      end
    end
    vectors++;
    if ({r_cnt, g_cnt} !== {32'd4, 32'd16}) begin
      miscompares++;
      $display("FAIL colour_count_b: got r=%0d g=%0d expected r=4 g=16", r_cnt, g_cnt);
    end
  endtask

  task automatic test_frame;
    int last_fs = -1;
    int low_run = 0;
    bit seen_fall = 0;
    logic [9:0] prev_x, prev_y;
    logic prev_vs;
    for (int c = 0; c < 4 * BHT * BVT; c++) begin
      {r_b, g_b, b_b} = 3'($urandom);
      prev_x  = b_x;
      prev_y  = b_y;
      prev_vs = b_vs;
      @(negedge clk);
      vectors++;
      if (obs_b !== exp_b) begin
        miscompares++;
        $display("FAIL frame_model_b: got %h expected %h", obs_b, exp_b);
      end
      if (b_fs) begin
        if (last_fs >= 0) begin
          vectors++;
          if (c - last_fs !== BHT * BVT) begin
            miscompares++;
            $display("FAIL frame_period: got %0d expected %0d", c - last_fs, BHT * BVT);
          end
        end
        last_fs = c;
      end
      if (prev_x == 10'd6 && prev_y == 10'd4) begin
        vectors++;
        if ({b_x, b_y} !== 20'd0) begin
          miscompares++;
          $display("FAIL y_wrap: got x=%0d y=%0d expected 0 0", b_x, b_y);
        end
      end
      if (!b_hs) begin
        vectors++;
        if (prev_x !== 10'd5) begin
          miscompares++;
          $display("FAIL hsync_b_pos: got x=%0d expected 5", prev_x);
        end
      end
      if (!b_vs) low_run++;
      if (prev_vs && !b_vs) seen_fall = 1;
      if (!prev_vs && b_vs) begin
        if (seen_fall) begin
          vectors++;
          if (low_run !== BVS * BHT) begin
            miscompares++;
            $display("FAIL vsync_width: got %0d expected %0d", low_run, BVS * BHT);
          end
        end
        low_run = 0;
      end
    end
  endtask

  task automatic test_mid_reset;
    int low_run = 0;
    int guard = 0;
    bit seen_fall = 0;
    logic prev_vs;
    while (!(b_x == 10'd2 && b_y == 10'd3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL mid_reset_b_reach: got timeout expected x=2 y=3");
    end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    vectors++;
    if (obs_b !== {10'd6, 10'd4, 8'b00000011}) begin
      miscompares++;
      $display("FAIL mid_reset_b: got %h expected %h", obs_b, {10'd6, 10'd4, 8'b00000011});
    end
    for (int c = 0; c < 2 * BHT * BVT; c++) begin
      {r_b, g_b, b_b} = 3'($urandom);
      prev_vs = b_vs;
      @(negedge clk);
      vectors++;
      if (obs_b !== exp_b) begin
        miscompares++;
        $display("FAIL mid_reset_model_b: got %h expected %h", obs_b, exp_b);
      end
      if (!b_vs) low_run++;
      if (prev_vs && !b_vs) seen_fall = 1;
      if (!prev_vs && b_vs) begin
        vectors++;
        if (!seen_fall || low_run !== BVS * BHT) begin
          miscompares++;
          $display("FAIL mid_reset_vsync: got %0d expected %0d", low_run, BVS * BHT);
        end
        low_run = 0;
      end
    end
    guard = 0;
    while (a_x != 10'd300 && guard < 2 * AHT) begin
      @(negedge clk);
      guard++;
    end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    vectors++;
    if (obs_a !== {10'd799, 10'd524, 8'b00000011}) begin
      miscompares++;
      $display("FAIL mid_reset_a: got %h expected %h", obs_a, {10'd799, 10'd524, 8'b00000011});
    end
    @(negedge clk);
    vectors++;
    if ({a_x, a_y, a_vis, a_fs, a_ls, a_hs, a_vs} !== {20'd0, 5'b11111}) begin
      miscompares++;
      $display("FAIL mid_reset_a_restart: got %h expected %h", obs_a, exp_a);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_colour();
    test_frame();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
